// File: rtl/mem_port_arbiter.sv
// Round-robin burst sequencer sharing one main-memory word port between the
// I-cache and D-cache miss controllers; one word in flight at a time.
module mem_port_arbiter #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned MEM_LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned AW  = 32;
  localparam int unsigned OFF = LINE_ADDR_LEN + 2;
  localparam int unsigned BW  = AW - OFF;
  localparam int unsigned IW  = LINE_ADDR_LEN;
  localparam int unsigned LW  = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            we_q, we_d;
  logic [BW-1:0]   base_q, base_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [31:0]     i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic            i_done_q, i_done_d, d_done_q, d_done_d;
  logic            d_wready_q, d_wready_d;
  logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;
  logic            issue;

  // Line-offset bits of the request addresses are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

  // Next state and next registered outputs; issue outputs are loaded on entry to ISSUE.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    base_d      = base_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    d_wready_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // grant_q doubles as last owner: on a tie the other requester wins.
          grant_d = d_req && (!i_req || !grant_q);
          we_d    = grant_d && d_we;
          base_d  = grant_d ? d_addr[AW-1:OFF] : i_addr[AW-1:OFF];
          idx_d   = '0;
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        lat_d   = LW'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LW'(1)) begin
          if (!we_q) begin
            if (grant_q) begin
              d_rdata_d  = mem_rdata;
              d_rvalid_d = 1'b1;
            end else begin
              i_rdata_d  = mem_rdata;
              i_rvalid_d = 1'b1;
            end
          end
          if (idx_q == '1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ISSUE;
            issue   = 1'b1;
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      mem_en_d   = 1'b1;
      mem_we_d   = we_d;
      mem_addr_d = {base_d, idx_d, 2'b00};
      if (we_d) begin
        mem_wdata_d = d_wdata;
        d_wready_d  = 1'b1;
      end
    end

    if (state_d == DONE) begin
      i_done_d = !grant_d;
      d_done_d = grant_d;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      d_wready_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      d_wready_q  <= d_wready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_done    = i_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_done    = d_done_q;
  assign d_wready  = d_wready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one 8-word/latency-2 instance and one
// 2-word/latency-1 instance; memory returns addr ^ 0xA5A5_0000.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;

  // Instance A: LINE_ADDR_LEN=3, MEM_LAT=2
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_rvalid, i_done, d_wready, d_rvalid, d_done;
  logic        mem_en, mem_we, busy, grant;
  logic [31:0] p0, p1;

  // Instance B: LINE_ADDR_LEN=1, MEM_LAT=1
  logic        i_req6, d_req6, d_we6;
  logic [31:0] i_addr6, d_addr6, d_wdata6, mem_rdata6;
  logic [31:0] i_rdata6, d_rdata6, mem_addr6, mem_wdata6;
  logic        i_rvalid6, i_done6, d_wready6, d_rvalid6, d_done6;
  logic        mem_en6, mem_we6, busy6, grant6;
  logic [31:0] q0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_ADDR_LEN(3), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  mem_port_arbiter #(.LINE_ADDR_LEN(1), .MEM_LAT(1)) u_dut6 (
    .clk(clk), .rst(rst),
    .i_req(i_req6), .i_addr(i_addr6), .i_rdata(i_rdata6), .i_rvalid(i_rvalid6), .i_done(i_done6),
    .d_req(d_req6), .d_we(d_we6), .d_addr(d_addr6), .d_wdata(d_wdata6), .d_wready(d_wready6),
    .d_rdata(d_rdata6), .d_rvalid(d_rvalid6), .d_done(d_done6),
    .mem_en(mem_en6), .mem_we(mem_we6), .mem_addr(mem_addr6), .mem_wdata(mem_wdata6),
    .mem_rdata(mem_rdata6), .busy(busy6), .grant(grant6)
  );

  // Memory models: read data valid MEM_LAT cycles after the issue cycle.
  always @(posedge clk) begin
    p0 <= mem_en ? (mem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    p1 <= p0;
    q0 <= mem_en6 ? (mem_addr6 ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end
  assign mem_rdata  = p1;
  assign mem_rdata6 = q0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Ticks until the selected done pulse is seen; n is ticks taken.
  task automatic wait_done(input string tag, input bit sel_d, input int limit, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = sel_d ? d_done : i_done;
    end
    chk1(tag, seen, 1'b1);
  endtask

  initial begin
    int n;
    int cnt;
    logic en_e, rv_e;

    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    i_req6 = 0; d_req6 = 0; d_we6 = 0; i_addr6 = '0; d_addr6 = '0; d_wdata6 = '0;
    tick();
    tick();
    chk("rst_outs", {22'd0, mem_en, mem_we, i_rvalid, i_done, d_rvalid, d_done,
                     d_wready, busy, grant, busy6}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Simultaneous requests: D first, then I, then D again.
    i_req = 1; d_req = 1; i_addr = 32'h0000_3000; d_addr = 32'h0000_2000; d_we = 0;
    tick();
    chk1("t2_grant_d", grant, 1'b1);
    chk1("t2_en_d", mem_en, 1'b1);
    chk("t2_addr_d", mem_addr, 32'h0000_2000);
    wait_done("t2_d_done_seen", 1'b1, 40, n);
    chk("t2_d_len", n, 24);
    d_req = 0;
    tick();
    chk1("t2_idle_busy", busy, 1'b0);
    chk1("t2_idle_grant", grant, 1'b1);
    tick();
    chk1("t2_grant_i", grant, 1'b0);
    chk("t2_addr_i", mem_addr, 32'h0000_3000);
    wait_done("t2_i_done_seen", 1'b0, 40, n);
    i_req = 0;
    tick();
    i_req = 1; d_req = 1;
    tick();
    chk1("t2_grant_d2", grant, 1'b1);
    chk("t2_addr_d2", mem_addr, 32'h0000_2000);
    wait_done("t2_d2_done_seen", 1'b1, 40, n);
    i_req = 0; d_req = 0;
    tick();

    // Single I-cache refill burst with full timing.
    i_req = 1; i_addr = 32'h0000_1234;
    for (int c = 1; c <= 26; c++) begin
      tick();
      en_e = (c <= 22) && ((c - 1) % 3 == 0);
      rv_e = (c >= 4) && (c <= 25) && ((c - 4) % 3 == 0);
      chk1("t1_mem_en", mem_en, en_e);
      chk1("t1_mem_we", mem_we, 1'b0);
      if (en_e) chk("t1_mem_addr", mem_addr, 32'h0000_1220 + 32'((c - 1) / 3) * 32'd4);
      chk1("t1_i_rvalid", i_rvalid, rv_e);
      if (rv_e) chk("t1_i_rdata", i_rdata, (32'h0000_1220 + 32'((c - 4) / 3) * 32'd4) ^ 32'hA5A5_0000);
      chk1("t1_d_rvalid", d_rvalid, 1'b0);
      chk1("t1_i_done", i_done, c == 25);
      chk1("t1_busy", busy, c <= 25);
      if (c == 25) i_req = 0;
    end

    // D-cache writeback burst; requester advances d_wdata on d_wready.
    d_req = 1; d_we = 1; d_addr = 32'h0000_0040; d_wdata = 32'd0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      en_e = (c <= 22) && ((c - 1) % 3 == 0);
      chk1("t3_mem_en", mem_en, en_e);
      chk1("t3_wready", d_wready, en_e);
      if (en_e) begin
        chk1("t3_mem_we", mem_we, 1'b1);
        chk("t3_mem_addr", mem_addr, 32'h0000_0040 + 32'((c - 1) / 3) * 32'd4);
        chk("t3_mem_wdata", mem_wdata, 32'((c - 1) / 3));
      end
      chk1("t3_d_rvalid", d_rvalid, 1'b0);
      chk1("t3_d_done", d_done, c == 25);
      if (d_wready) d_wdata = d_wdata + 32'd1;
      if (c == 25) begin d_req = 0; d_we = 0; end
    end

    // I request dropped mid-burst; D request raised mid-burst waits.
    i_req = 1; i_addr = 32'h0000_5000; cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (mem_en) cnt++;
      if (c == 5) i_req = 0;
      if (c == 8) begin d_req = 1; d_addr = 32'h0000_6000; end
      if (c == 10) chk1("t4_grant_hold", grant, 1'b0);
      if (c == 25) chk1("t4_i_done", i_done, 1'b1);
    end
    chk("t4_issue_count", cnt, 8);
    tick();
    chk1("t4_idle_busy", busy, 1'b0);
    tick();
    chk1("t4_grant_d", grant, 1'b1);
    chk("t4_addr_d", mem_addr, 32'h0000_6000);
    wait_done("t4_d_done_seen", 1'b1, 40, n);
    d_req = 0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    i_req = 1; i_addr = 32'h0000_7000;
    tick();
    tick();
    chk1("t5_busy_before", busy, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("t5_outs_zero", {23'd0, mem_en, mem_we, i_rvalid, i_done, d_rvalid, d_done,
                         d_wready, busy, grant}, 32'd0);
    chk("t5_addr_zero", mem_addr, 32'd0);
    i_req = 0;
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (i_done || busy) cnt++;
    end
    chk("t5_no_done", cnt, 0);
    i_req = 1; i_addr = 32'h0000_8000;
    wait_done("t5_new_done_seen", 1'b0, 40, n);
    chk("t5_new_len", n, 25);
    i_req = 0;
    tick();

    // Small instance: address wrap and 5-cycle occupancy.
    d_req6 = 1; d_addr6 = 32'hFFFF_FFF8; cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (busy6) cnt++;
      chk1("t6_mem_en", mem_en6, (c == 1) || (c == 3));
      if (c == 1) chk("t6_addr0", mem_addr6, 32'hFFFF_FFF8);
      if (c == 3) chk("t6_addr1", mem_addr6, 32'hFFFF_FFFC);
      chk1("t6_rvalid", d_rvalid6, (c == 3) || (c == 5));
      if (c == 3) chk("t6_rdata0", d_rdata6, 32'h5A5A_FFF8);
      if (c == 5) chk("t6_rdata1", d_rdata6, 32'h5A5A_FFFC);
      chk1("t6_done", d_done6, c == 5);
      if (c == 5) d_req6 = 0;
    end
    chk("t6_occupancy", cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
